// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: timing counters, 3x3-upscaled framebuffer reads, registered RGB/sync.
// Optional VGA_SCANOUT_TEST_PATTERN_EN adds test_pattern_sel for vertical colour bars.
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned FB_WIDTH = 214,
  parameter int unsigned SCALE    = 3
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic        test_pattern_sel,
`endif
  input  logic [2:0]  fb_data,
  output logic [15:0] fb_addr,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);
  localparam int unsigned SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned COL_MAX = (H_TOTAL - 1) / SCALE;
  localparam int unsigned CW      = $clog2(COL_MAX + 1);
  localparam int unsigned AW      = 16;

  // stage 0 position state
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [SW-1:0] x_sub, x_sub_n, y_sub, y_sub_n;
  logic [CW-1:0] fb_col, fb_col_n;
  logic [AW-1:0] row_base, row_base_n, addr_n;
  logic          vis_n;
  logic          vis0, hs0, vs0;

  // stage 1 delayed qualifiers (sync kept active-high internally)
  logic          vis1, hs1, vs1;

  // Next position; fb_addr is built from next state so it lines up with the counters.
  always_comb begin
    x_n        = x + XW'(1);
    y_n        = y;
    x_sub_n    = x_sub + SW'(1);
    fb_col_n   = fb_col;
    y_sub_n    = y_sub;
    row_base_n = row_base;
    if (x_sub == SW'(SCALE - 1)) begin
      x_sub_n  = '0;
      fb_col_n = fb_col + CW'(1);
    end
    if (x == XW'(H_TOTAL - 1)) begin
      x_n      = '0;
      x_sub_n  = '0;
      fb_col_n = '0;
      if (y == YW'(V_TOTAL - 1)) begin
        y_n        = '0;
        y_sub_n    = '0;
        row_base_n = '0;
      end else begin
        y_n = y + YW'(1);
        if (y_sub == SW'(SCALE - 1)) begin
          y_sub_n    = '0;
          row_base_n = row_base + AW'(FB_WIDTH);
        end else begin
          y_sub_n = y_sub + SW'(1);
        end
      end
    end
    vis_n  = (x_n < XW'(H_ACTIVE)) && (y_n < YW'(V_ACTIVE));
    addr_n = vis_n ? (row_base_n + AW'(fb_col_n)) : '0;
  end

  always_comb begin
    vis0 = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
    hs0  = (x >= XW'(H_ACTIVE + H_FRONT)) && (x < XW'(H_ACTIVE + H_FRONT + H_SYNC));
    vs0  = (y >= YW'(V_ACTIVE + V_FRONT)) && (y < YW'(V_ACTIVE + V_FRONT + V_SYNC));
  end

  // stage 0 counters and address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      x_sub    <= '0;
      y_sub    <= '0;
      fb_col   <= '0;
      row_base <= '0;
      fb_addr  <= '0;
    end else begin
      x        <= x_n;
      y        <= y_n;
      x_sub    <= x_sub_n;
      y_sub    <= y_sub_n;
      fb_col   <= fb_col_n;
      row_base <= row_base_n;
      fb_addr  <= addr_n;
    end
  end

  // vblank strobe is taken straight from the counters, not the pixel pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblank_start <= 1'b0;
    end else begin
      vblank_start <= (x == '0) && (y == YW'(V_ACTIVE));
    end
  end

  // stage 1: framebuffer data returns alongside these
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vis1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
    end else begin
      vis1 <= vis0;
      hs1  <= hs0;
      vs1  <= vs0;
    end
  end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic [5:0] col6;
  logic [2:0] pat1;
  logic [2:0] pix;

  assign col6 = 6'(fb_col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat1 <= '0;
    end else begin
      pat1 <= col6[5:3];
    end
  end

  assign pix = test_pattern_sel ? pat1 : fb_data;
`else
  logic [2:0] pix;
  assign pix = fb_data;
`endif

  // stage 2: pin registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r     <= 1'b0;
      vga_g     <= 1'b0;
      vga_b     <= 1'b0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      vga_r     <= vis1 & pix[2];
      vga_g     <= vis1 & pix[1];
      vga_b     <= vis1 & pix[0];
      vga_hsync <= ~hs1;
      vga_vsync <= ~vs1;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a full-size instance plus a shrunken-timing instance for frame-level behaviour.
module tb_vga_scanout;

  localparam int M_HA = 640, M_HF = 16, M_HS = 96, M_HB = 48;
  localparam int M_VA = 480, M_VF = 10, M_VS = 2, M_VB = 33, M_FBW = 214, M_SC = 3;
  localparam int S_HA = 12, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VA = 9, S_VF = 2, S_VS = 2, S_VB = 2, S_FBW = 4, S_SC = 3;
  localparam int M_HT = M_HA + M_HF + M_HS + M_HB, M_VT = M_VA + M_VF + M_VS + M_VB;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB, S_VT = S_VA + S_VF + S_VS + S_VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pat = 1'b0;
  int   mode = 0;

  logic [15:0] m_addr, s_addr;
  logic [2:0]  m_data, s_data;
  logic m_r, m_g, m_b, m_hs, m_vs, m_vb;
  logic s_r, s_g, s_b, s_hs, s_vs, s_vb;

  int n_checks = 0;
  int n_errors = 0;

  int mx, my, sx, sy, cyc;
  logic prev_vb_m, prev_vb_s, prev_hs_m;
  int hs_fall1, hs_rise1, hs_fall2, vb_cnt_m, vb_cnt_s;
  logic [4:0] q_m[$];
  logic [4:0] q_s[$];

  always #5 clk = ~clk;

  vga_scanout u_main (
    .clk(clk), .rst(rst),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .test_pattern_sel(pat),
`endif
    .fb_data(m_data), .fb_addr(m_addr),
    .vga_r(m_r), .vga_g(m_g), .vga_b(m_b),
    .vga_hsync(m_hs), .vga_vsync(m_vs), .vblank_start(m_vb)
  );

  vga_scanout #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .FB_WIDTH(S_FBW), .SCALE(S_SC)
  ) u_small (
    .clk(clk), .rst(rst),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .test_pattern_sel(pat),
`endif
    .fb_data(s_data), .fb_addr(s_addr),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .vga_hsync(s_hs), .vga_vsync(s_vs), .vblank_start(s_vb)
  );

  function automatic logic [2:0] fb_fn(input int md, input logic [15:0] a);
    case (md)
      0:       return (a == 16'd5) ? 3'b101 : 3'b000;
      1:       return 3'b111;
      default: return 3'(a ^ (a >> 3) ^ (a >> 6));
    endcase
  endfunction

  // framebuffer read ports with one cycle of latency
  always @(posedge clk) begin
    m_data <= fb_fn(mode, m_addr);
    s_data <= fb_fn(mode, s_addr);
  end

  function automatic int exp_addr(input int x, y, ha, va, sc, fbw);
    if (x < ha && y < va) return (y / sc) * fbw + x / sc;
    return 0;
  endfunction

  function automatic logic [4:0] exp_pins(input int x, y, ha, hf, hs, va, vf, vs, sc, fbw, md,
                                          input logic sel);
    logic [2:0] c;
    logic hsn, vsn;
    int a;
    a = exp_addr(x, y, ha, va, sc, fbw);
    c = 3'b000;
    if (x < ha && y < va) c = sel ? 3'((x / sc) / 8) : fb_fn(md, 16'(a));
    hsn = !((x >= ha + hf) && (x < ha + hf + hs));
    vsn = !((y >= va + vf) && (y < va + vf + vs));
    return {c, hsn, vsn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // compare the current cycle against the scoreboard, then queue this position's pins
  task automatic sample();
    logic [4:0] e;
    e = 5'h1f;
    if (q_m.size() > 0) e = q_m.pop_front();
    check("main_pins", {27'd0, m_r, m_g, m_b, m_hs, m_vs}, {27'd0, e});
    check("main_addr", {16'd0, m_addr}, exp_addr(mx, my, M_HA, M_VA, M_SC, M_FBW));
    check("main_vblank", {31'd0, m_vb}, {31'd0, prev_vb_m});
    q_m.push_back(exp_pins(mx, my, M_HA, M_HF, M_HS, M_VA, M_VF, M_VS, M_SC, M_FBW, mode, pat));
    prev_vb_m = (mx == 0 && my == M_VA);

    e = 5'h1f;
    if (q_s.size() > 0) e = q_s.pop_front();
    check("small_pins", {27'd0, s_r, s_g, s_b, s_hs, s_vs}, {27'd0, e});
    check("small_addr", {16'd0, s_addr}, exp_addr(sx, sy, S_HA, S_VA, S_SC, S_FBW));
    check("small_vblank", {31'd0, s_vb}, {31'd0, prev_vb_s});
    q_s.push_back(exp_pins(sx, sy, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, S_SC, S_FBW, mode, pat));
    prev_vb_s = (sx == 0 && sy == S_VA);

    if (prev_hs_m && !m_hs) begin
      if (hs_fall1 < 0) hs_fall1 = cyc;
      else if (hs_fall2 < 0) hs_fall2 = cyc;
    end
    if (!prev_hs_m && m_hs && hs_rise1 < 0) hs_rise1 = cyc;
    prev_hs_m = m_hs;
    if (m_vb) vb_cnt_m++;
    if (s_vb) vb_cnt_s++;
  endtask

  task automatic advance();
    cyc++;
    mx++;
    if (mx == M_HT) begin
      mx = 0;
      my = (my == M_VT - 1) ? 0 : my + 1;
    end
    sx++;
    if (sx == S_HT) begin
      sx = 0;
      sy = (sy == S_VT - 1) ? 0 : sy + 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      @(negedge clk);
      advance();
    end
  endtask

  task automatic reset_release(input int md, input logic sel);
    rst  = 1'b1;
    mode = md;
    pat  = sel;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    mx = 0; my = 0; sx = 0; sy = 0; cyc = 0;
    q_m.delete();
    q_s.delete();
    // two pipeline slots still hold reset values after release
    q_m.push_back(5'b00011); q_m.push_back(5'b00011);
    q_s.push_back(5'b00011); q_s.push_back(5'b00011);
    prev_vb_m = 1'b0; prev_vb_s = 1'b0; prev_hs_m = 1'b1;
    hs_fall1 = -1; hs_rise1 = -1; hs_fall2 = -1;
    vb_cnt_m = 0; vb_cnt_s = 0;
  endtask

  initial begin
    // single-pixel framebuffer pattern, line timing
    reset_release(0, 1'b0);
    run(2500);
    check("hs_first_fall", hs_fall1, 658);
    check("hs_first_rise", hs_rise1, 754);
    check("hs_second_fall", hs_fall2, 1458);

    // all-white framebuffer, then asynchronous reset mid-line
    reset_release(1, 1'b0);
    run(2 * M_HT + 300);
    check("pre_reset_pos", mx * 1000 + my, 300002);
    sample();
    #2;
    rst = 1'b1;
    #1;
    check("async_main_pins", {27'd0, m_r, m_g, m_b, m_hs, m_vs}, 32'h3);
    check("async_main_addr", {16'd0, m_addr}, 0);
    check("async_main_vblank", {31'd0, m_vb}, 0);
    check("async_small_pins", {27'd0, s_r, s_g, s_b, s_hs, s_vs}, 32'h3);
    check("async_small_addr", {16'd0, s_addr}, 0);

    // hashed framebuffer contents, several small frames
    reset_release(2, 1'b0);
    run(3000);
    check("restart_hs_fall", hs_fall1, 658);
    check("small_vblank_count", vb_cnt_s, 10);
    check("main_vblank_count", vb_cnt_m, 0);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    reset_release(2, 1'b1);
    run(1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
